device_bus_arbiter: RTL



---
 rtl/device_bus_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/device_bus_arbiter.sv
// Two-master round-robin arbiter and address decoder for the shared 16-bit device bus.
// Each grant takes IDLE->ADDR->DATA (ack 2 cycles after req is seen); a losing master waits with req held.
module device_bus_arbiter #(
  parameter int         NUM_DEVICES  = 16,
  parameter logic [3:0] CONTROL_PAGE = 4'h0
) (
  input  logic                      cpu_clock,
  input  logic                      reset,
  input  logic                      m0_req,
  input  logic                      m0_write,
  input  logic [15:0]               m0_address,
  input  logic [15:0]               m0_wdata,
  output logic                      m0_ack,
  output logic [15:0]               m0_rdata,
  input  logic                      m1_req,
  input  logic                      m1_write,
  input  logic [15:0]               m1_address,
  input  logic [15:0]               m1_wdata,
  output logic                      m1_ack,
  output logic [15:0]               m1_rdata,
  output logic                      device_write_en,
  output logic [15:0]               device_address,
  output logic [15:0]               device_data_out,
  output logic [NUM_DEVICES-1:0]    device_sel,
  input  logic [NUM_DEVICES*16-1:0] device_rdata,
  output logic                      bus_error,
  output logic [1:0]                grant
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]  r_state;
  logic        r_owner;
  logic        r_last;
  logic        r_write;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;

  logic                   w_pick;
  logic                   w_addr_ph;
  logic                   w_data_ph;
  logic                   w_busy;
  logic                   w_is_control;
  logic [3:0]             w_dev_id;
  logic                   w_valid;
  logic [15:0]            w_slot;
  logic [NUM_DEVICES-1:0] w_onehot;

  // r_owner/r_last: 0 = m0, 1 = m1; on a tie the master not served last wins
  always_comb begin
    w_pick = m1_req;
    if (m0_req && m1_req) w_pick = ~r_last;
  end

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_write <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            r_owner <= w_pick;
            r_write <= w_pick ? m1_write   : m0_write;
            r_addr  <= w_pick ? m1_address : m0_address;
            r_wdata <= w_pick ? m1_wdata   : m0_wdata;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: r_state <= S_DATA;
        S_DATA: begin
          r_last  <= r_owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_is_control = (r_addr[15:12] == CONTROL_PAGE);
  assign w_dev_id     = w_is_control ? r_addr[7:4] : r_addr[15:12];
  assign w_valid      = ({28'd0, w_dev_id} < 32'(NUM_DEVICES));

  // Slots beyond NUM_DEVICES never match, so an invalid ID yields zero data and no select
  always_comb begin
    w_slot   = 16'h0000;
    w_onehot = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (w_dev_id == i[3:0]) begin
        w_slot      = device_rdata[i*16 +: 16];
        w_onehot[i] = 1'b1;
      end
    end
  end

  assign w_addr_ph = (r_state == S_ADDR);
  assign w_data_ph = (r_state == S_DATA);
  assign w_busy    = w_addr_ph | w_data_ph;

  assign device_address  = w_busy ? r_addr  : 16'h0000;
  assign device_data_out = w_busy ? r_wdata : 16'h0000;
  assign device_sel      = (w_busy && w_valid) ? w_onehot : '0;
  assign device_write_en = w_addr_ph & r_write & w_valid;
  assign grant           = w_busy ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus_error       = w_data_ph & ~w_valid;

  assign m0_ack   = w_data_ph & ~r_owner;
  assign m1_ack   = w_data_ph &  r_owner;
  assign m0_rdata = (m0_ack && !r_write) ? w_slot : 16'h0000;
  assign m1_rdata = (m1_ack && !r_write) ? w_slot : 16'h0000;

endmodule
